// File: rtl/dram_refresh_sched.sv
// CBR refresh scheduler: owes one refresh every REFRESH_INTERVAL CLKCPU cycles and requests it in a bus-idle window.
// Optional macro REFRESH_URGENT_EN: a high backlog forces the request without waiting for an idle bus.
module dram_refresh_sched #(
    parameter int REFRESH_INTERVAL = 220,
    parameter int MAX_PENDING      = 8,
    parameter int PEND_W           = 4,
    parameter int URGENT_LEVEL     = 4
) (
    input  logic              CLKCPU,
    input  logic              RESET,
    input  logic              AS20,
    input  logic              REFRESH_ACK,
    output logic              REFRESH_REQ,
    output logic              REFRESH_URGENT,
    output logic [PEND_W-1:0] PENDING,
    output logic              OVERRUN
);

    localparam int TICK_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_INTERVAL - 1);
    localparam logic [PEND_W-1:0] MAX_P     = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_REQ  = 2'd2,
        ST_COOL = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick;
    logic                w_ack_ok;
    logic [PEND_W-1:0]   r_pending;
    logic [PEND_W-1:0]   w_pending_nxt;
    logic                r_overrun;
    logic                w_overrun_nxt;
    logic                r_req;
    logic                r_urgent;
    logic                w_urgent_nxt;

    // Urgency threshold beyond the saturation limit can never fire; the block only documents that.
    if (URGENT_LEVEL > MAX_PENDING) begin : g_urgent_unreachable
    end

    always_comb begin
        w_tick   = (r_tick_cnt == TICK_LAST);
        w_ack_ok = REFRESH_ACK && (r_state == ST_REQ);
    end

    // Owed-refresh bookkeeping: a tick and an ack on the same edge cancel, even at saturation.
    always_comb begin
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        if (w_tick && !w_ack_ok) begin
            if (r_pending == MAX_P) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_pending_nxt = r_pending + 1'b1;
            end
        end else if (!w_tick && w_ack_ok && (r_pending != '0)) begin
            w_pending_nxt = r_pending - 1'b1;
        end
    end

    always_comb begin
`ifdef REFRESH_URGENT_EN
        w_urgent_nxt = (w_pending_nxt >= PEND_W'(URGENT_LEVEL));
`else
        w_urgent_nxt = 1'b0;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef REFRESH_URGENT_EN
                if (r_urgent) begin
                    w_state_nxt = ST_REQ;
                end else if ((r_pending != '0) && AS20) begin
                    w_state_nxt = ST_ARM;
                end
`else
                if ((r_pending != '0) && AS20) begin
                    w_state_nxt = ST_ARM;
                end
`endif
            end
            ST_ARM:  w_state_nxt = AS20 ? ST_REQ : ST_IDLE;
            ST_REQ:  if (w_ack_ok) w_state_nxt = ST_COOL;
            ST_COOL: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_pending  <= '0;
            r_overrun  <= 1'b0;
            r_req      <= 1'b0;
            r_urgent   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_pending  <= w_pending_nxt;
            r_overrun  <= w_overrun_nxt;
            r_req      <= (w_state_nxt == ST_REQ);
            r_urgent   <= w_urgent_nxt;
        end
    end

    assign REFRESH_REQ    = r_req;
    assign REFRESH_URGENT = r_urgent;
    assign PENDING        = r_pending;
    assign OVERRUN        = r_overrun;

endmodule

// File: tb/tb_dram_refresh_sched.sv
// Randomised bench for dram_refresh_sched against a cycle-level behavioural model of the refresh rules.
module tb_dram_refresh_sched;

    localparam int RI = 10;
    localparam int MP = 3;
    localparam int PW = 4;
    localparam int UL = 2;
    localparam int W  = PW + 3;
`ifdef REFRESH_URGENT_EN
    localparam bit URG_EN = 1'b1;
`else
    localparam bit URG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          as20;
    logic          ack;
    logic          req;
    logic          urgent;
    logic [PW-1:0] pending;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    // Behavioural model: backlog, request flag, one-cycle cool-off, consecutive idle samples.
    int m_cyc;
    int m_pend;
    int m_idle_run;
    bit m_req;
    bit m_cool;
    bit m_ovr;
    bit m_urg;

    dram_refresh_sched #(
        .REFRESH_INTERVAL(RI),
        .MAX_PENDING(MP),
        .PEND_W(PW),
        .URGENT_LEVEL(UL)
    ) dut (
        .CLKCPU(clk),
        .RESET(rst),
        .AS20(as20),
        .REFRESH_ACK(ack),
        .REFRESH_REQ(req),
        .REFRESH_URGENT(urgent),
        .PENDING(pending),
        .OVERRUN(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit a, input bit ak);
        int  p0;
        bit  tick;
        bit  ack_ok;
        bit  urg0;
        if (r) begin
            m_cyc = 0; m_pend = 0; m_idle_run = 0;
            m_req = 0; m_cool = 0; m_ovr = 0; m_urg = 0;
        end else begin
            p0     = m_pend;
            urg0   = m_urg;
            tick   = ((m_cyc % RI) == RI - 1);
            m_cyc++;
            ack_ok = ak && m_req;
            if (tick && !ack_ok) begin
                if (m_pend == MP) m_ovr = 1;
                else m_pend++;
            end else if (!tick && ack_ok && m_pend > 0) begin
                m_pend--;
            end
            if (m_req) begin
                if (ack_ok) begin
                    m_req  = 0;
                    m_cool = 1;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (m_idle_run == 1) begin
                m_idle_run = 0;
                if (a) m_req = 1;
            end else if (URG_EN && urg0) begin
                m_req = 1;
            end else if (p0 != 0 && a) begin
                m_idle_run = 1;
            end
            m_urg = URG_EN && (m_pend >= UL);
        end
        exp_q.push_back({m_req, m_urg, m_ovr, PW'(m_pend)});
    endtask

    task automatic cycle(input bit r, input bit a, input bit ak);
        logic [W-1:0] e;
        rst  = r;
        as20 = a;
        ack  = ak;
        @(posedge clk);
        model_step(r, a, ak);
        @(negedge clk);
        e = exp_q.pop_front();
        check("req",     32'(req),     32'(e[W-1]));
        check("urgent",  32'(urgent),  32'(e[W-2]));
        check("overrun", 32'(overrun), 32'(e[W-3]));
        check("pending", 32'(pending), 32'(e[PW-1:0]));
    endtask

    initial begin
        int busy_pct;
        rst = 1'b1; as20 = 1'b1; ack = 1'b0;

        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        check("reset_req",     32'(req),     32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        // First tick lands on edge 10, request two edges later.
        repeat (12) cycle(1'b0, 1'b1, 1'b0);
        check("first_req",     32'(req),     32'd1);
        check("first_pending", 32'(pending), 32'd1);

        cycle(1'b0, 1'b1, 1'b1);
        check("ack_req",     32'(req),     32'd0);
        check("ack_pending", 32'(pending), 32'd0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0);

        // Busy bus from reset: four ticks saturate and then overrun.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (40) cycle(1'b0, 1'b0, 1'b0);
        check("busy_pending", 32'(pending), 32'(MP));
        check("busy_overrun", 32'(overrun), 32'd1);
        if (!URG_EN) check("busy_req", 32'(req), 32'd0);

        repeat (60) cycle(1'b0, 1'b1, m_req);

        // Spurious ack while idle, then reset in the middle of a request.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("midreset_req",     32'(req),     32'd0);
        check("midreset_pending", 32'(pending), 32'd0);

        for (int seg = 0; seg < 6; seg++) begin
            busy_pct = 10 + seg * 15;
            for (int i = 0; i < 500; i++) begin
                cycle($urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) >= busy_pct,
                      (m_req && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
